// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer.
//   opcode_t     : the legal major opcodes (instruction bits [6:0])
//   seq_state_t  : sequencer state encoding, also exported on state_o
//   Alu*         : alu_op encodings produced by the sequencer
//   Wb*          : wb_sel encodings (write-back source select)
package cpu_pkg;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpIAlu   = 7'b0010011,
        OpStore  = 7'b0100011,
        OpR      = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJal    = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5,
        StTrap      = 3'd6
    } seq_state_t;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b1000;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;
    localparam logic [1:0] WbImm = 2'd3;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OpLoad, OpIAlu, OpStore, OpR, OpLui, OpBranch, OpJal: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
//   master : the sequencer (consumes instruction fields and status, drives controls)
//   slave  : the datapath / memory side
// Optional: CPU_SEQUENCER_INSTRET_EN adds the 32-bit retired-instruction counter.
interface cpu_sequencer_if;
    // Instruction register fields and status
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        branch_taken;
    logic        mem_ready;
    logic        halt_req;
    // Strobes
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    // Datapath selects
    logic        pc_next_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    // Status
    logic        illegal;
    logic [2:0]  state_o;
    logic        busy;
`ifdef CPU_SEQUENCER_INSTRET_EN
    logic [31:0] instret;
`endif

    modport master (
        input  opcode, funct3, funct7_5, branch_taken, mem_ready, halt_req,
        output ir_we, pc_we, rf_we, mem_req, mem_we,
        output pc_next_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel,
        output illegal, state_o, busy
`ifdef CPU_SEQUENCER_INSTRET_EN
        , output instret
`endif
    );

    modport slave (
        output opcode, funct3, funct7_5, branch_taken, mem_ready, halt_req,
        input  ir_we, pc_we, rf_we, mem_req, mem_we,
        input  pc_next_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel,
        input  illegal, state_o, busy
`ifdef CPU_SEQUENCER_INSTRET_EN
        , input instret
`endif
    );

endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : cpu_sequencer_if.master (instruction fields, status, strobes, selects)
// Parameter MEM_WAIT_MAX: mem_ready wait cycles tolerated in FETCH/MEM before TRAP (0 = never).
// Optional macro CPU_SEQUENCER_INSTRET_EN: adds bus.instret, +1 on every pc_we cycle.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    cpu_sequencer_if.master   bus
);

    localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_WAIT_MAX - 1);
    localparam bit TimeoutEn = (MEM_WAIT_MAX != 0);

    seq_state_t      state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic            illegal_q, illegal_d;
`ifdef CPU_SEQUENCER_INSTRET_EN
    logic [31:0]     instret_q, instret_d;
`endif

    logic       ir_we, pc_we, rf_we, mem_req, mem_we;
    logic       pc_next_sel, alu_a_sel, alu_b_sel;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       to_fetch;
    logic       timeout;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_next_sel = 1'b0;
        alu_a_sel   = 1'b0;
        alu_b_sel   = 1'b0;
        alu_op      = AluAdd;
        wb_sel      = WbAlu;
        to_fetch    = 1'b0;
        // This cycle is the MEM_WAIT_MAX-th consecutive cycle without mem_ready
        timeout     = TimeoutEn && (wait_q == WaitLast);

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StDecode: begin
                if (op_legal(bus.opcode)) begin
                    state_d = StExecute;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExecute: begin
                case (bus.opcode)
                    OpR: begin
                        alu_op  = {bus.funct7_5, bus.funct3};
                        state_d = StWriteback;
                    end
                    OpIAlu: begin
                        // bit 30 only selects SRAI vs SRLI; elsewhere it is immediate
                        alu_op    = {(bus.funct3 == 3'b101) & bus.funct7_5, bus.funct3};
                        alu_b_sel = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpLui: state_d = StWriteback;
                    OpJal: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpLoad, OpStore: begin
                        alu_b_sel = 1'b1;
                        state_d   = StMem;
                    end
                    OpBranch: begin
                        alu_op      = AluSub;
                        pc_we       = 1'b1;
                        pc_next_sel = bus.branch_taken;
                        to_fetch    = 1'b1;
                    end
                    default: begin
                        // IR changed under us; treat like an illegal decode
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (bus.opcode == OpStore);
                if (bus.mem_ready) begin
                    if (bus.opcode == OpLoad) begin
                        state_d = StWriteback;
                    end else begin
                        pc_we    = 1'b1;
                        to_fetch = 1'b1;
                    end
                end else if (timeout) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StWriteback: begin
                rf_we       = 1'b1;
                pc_we       = 1'b1;
                pc_next_sel = (bus.opcode == OpJal);
                case (bus.opcode)
                    OpLoad:  wb_sel = WbMem;
                    OpJal:   wb_sel = WbPc4;
                    OpLui:   wb_sel = WbImm;
                    default: wb_sel = WbAlu;
                endcase
                to_fetch = 1'b1;
            end
            StHalt: begin
                if (!bus.halt_req) state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: begin
                state_d   = StTrap;
                illegal_d = 1'b1;
            end
        endcase

        // halt_req is only honoured at instruction boundaries
        if (to_fetch) state_d = bus.halt_req ? StHalt : StFetch;

        if (bus.mem_ready || (state_d != state_q)) wait_d = '0;

        // Strobes drop asynchronously with reset, even mid-handshake
        if (!reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end

`ifdef CPU_SEQUENCER_INSTRET_EN
        instret_d = instret_q + {31'd0, pc_we};
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
`ifdef CPU_SEQUENCER_INSTRET_EN
            instret_q <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
`ifdef CPU_SEQUENCER_INSTRET_EN
            instret_q <= instret_d;
`endif
        end
    end

    assign bus.ir_we       = ir_we;
    assign bus.pc_we       = pc_we;
    assign bus.rf_we       = rf_we;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.pc_next_sel = pc_next_sel;
    assign bus.alu_a_sel   = alu_a_sel;
    assign bus.alu_b_sel   = alu_b_sel;
    assign bus.alu_op      = alu_op;
    assign bus.wb_sel      = wb_sel;
    assign bus.illegal     = illegal_q;
    assign bus.state_o     = state_q;
    assign bus.busy        = (state_q != StHalt) && (state_q != StTrap);
`ifdef CPU_SEQUENCER_INSTRET_EN
    assign bus.instret     = instret_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (MEM_WAIT_MAX = 4).
module tb_cpu_sequencer;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .MEM_WAIT_MAX (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Full 4-cycle FETCH/DECODE/EXECUTE/WRITEBACK instruction with mem_ready high
    task automatic run_wb(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] e_alu, input logic e_a,
                          input logic e_b, input logic [1:0] e_wb, input logic e_pcsel);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7_5  = f7;
        bus.mem_ready = 1'b1;
        #1;
        chk({tag, " F state"}, 32'(bus.state_o), 0);
        chk({tag, " F ir_we"}, 32'(bus.ir_we), 1);
        tick();
        chk({tag, " D state"}, 32'(bus.state_o), 1);
        tick();
        chk({tag, " E state"}, 32'(bus.state_o), 2);
        chk({tag, " E alu_op"}, 32'(bus.alu_op), 32'(e_alu));
        chk({tag, " E alu_a_sel"}, 32'(bus.alu_a_sel), 32'(e_a));
        chk({tag, " E alu_b_sel"}, 32'(bus.alu_b_sel), 32'(e_b));
        tick();
        chk({tag, " W state"}, 32'(bus.state_o), 4);
        chk({tag, " W rf_we"}, 32'(bus.rf_we), 1);
        chk({tag, " W pc_we"}, 32'(bus.pc_we), 1);
        chk({tag, " W wb_sel"}, 32'(bus.wb_sel), 32'(e_wb));
        chk({tag, " W pc_next_sel"}, 32'(bus.pc_next_sel), 32'(e_pcsel));
        chk({tag, " W alu_op"}, 32'(bus.alu_op), 0);
        tick();
        chk({tag, " next state"}, 32'(bus.state_o), 0);
    endtask

    initial begin
`ifdef CPU_SEQUENCER_INSTRET_EN
        logic [31:0] ir_snap;
`endif
        checks           = 0;
        errors           = 0;
        reset            = 1'b0;
        bus.opcode       = 7'd0;
        bus.funct3       = 3'd0;
        bus.funct7_5     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b1;
        bus.halt_req     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst state", 32'(bus.state_o), 0);
        chk("rst mem_req", 32'(bus.mem_req), 0);
        chk("rst ir_we", 32'(bus.ir_we), 0);
        chk("rst illegal", 32'(bus.illegal), 0);
        chk("rst busy", 32'(bus.busy), 1);
`ifdef CPU_SEQUENCER_INSTRET_EN
        chk("rst instret", bus.instret, 0);
`endif
        reset = 1'b1;
        #1;
        chk("post-rst mem_req", 32'(bus.mem_req), 1);
        chk("post-rst mem_we", 32'(bus.mem_we), 0);

        // ALU-class instructions
        run_wb("ADD",  7'b0110011, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        run_wb("SUB",  7'b0110011, 3'b000, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0);
        run_wb("SRAI", 7'b0010011, 3'b101, 1'b1, 4'b1101, 1'b0, 1'b1, 2'd0, 1'b0);
        run_wb("ADDI", 7'b0010011, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
        run_wb("LUI",  7'b0110111, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
        run_wb("JAL",  7'b1101111, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1);

        // LOAD with three wait cycles in MEM
        bus.opcode = 7'b0000011;
        #1;
        chk("LD F ir_we", 32'(bus.ir_we), 1);
        tick();
        tick();
        chk("LD E state", 32'(bus.state_o), 2);
        chk("LD E alu_b_sel", 32'(bus.alu_b_sel), 1);
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.mem_ready = 1'b1;
                #1;
            end
            chk("LD M state", 32'(bus.state_o), 3);
            chk("LD M mem_req", 32'(bus.mem_req), 1);
            chk("LD M mem_we", 32'(bus.mem_we), 0);
            if (i < 3) tick();
        end
        tick();
        chk("LD W state", 32'(bus.state_o), 4);
        chk("LD W wb_sel", 32'(bus.wb_sel), 1);
        chk("LD W rf_we", 32'(bus.rf_we), 1);
        tick();
        chk("LD next state", 32'(bus.state_o), 0);

        // BRANCH taken then not taken, 3 cycles each
        for (int t = 1; t >= 0; t--) begin
            bus.opcode       = 7'b1100011;
            bus.branch_taken = 1'(t);
            tick();
            tick();
            chk("BR E state", 32'(bus.state_o), 2);
            chk("BR E alu_op", 32'(bus.alu_op), 32'b1000);
            chk("BR E pc_we", 32'(bus.pc_we), 1);
            chk("BR E pc_next_sel", 32'(bus.pc_next_sel), 32'(t));
            chk("BR E rf_we", 32'(bus.rf_we), 0);
            tick();
            chk("BR next state", 32'(bus.state_o), 0);
            chk("BR next rf_we", 32'(bus.rf_we), 0);
        end
        bus.branch_taken = 1'b0;

        // STORE with halt_req raised during the MEM handshake
        bus.opcode = 7'b0100011;
        tick();
        tick();
        chk("ST E alu_b_sel", 32'(bus.alu_b_sel), 1);
        bus.mem_ready = 1'b0;
        tick();
        chk("ST M state", 32'(bus.state_o), 3);
        chk("ST M mem_we", 32'(bus.mem_we), 1);
        bus.halt_req = 1'b1;
        tick();
        chk("ST M held under halt", 32'(bus.state_o), 3);
        chk("ST M mem_req under halt", 32'(bus.mem_req), 1);
        bus.mem_ready = 1'b1;
        #1;
        chk("ST M pc_we", 32'(bus.pc_we), 1);
        chk("ST M pc_next_sel", 32'(bus.pc_next_sel), 0);
`ifdef CPU_SEQUENCER_INSTRET_EN
        ir_snap = bus.instret;
`endif
        tick();
        chk("HALT state", 32'(bus.state_o), 5);
        chk("HALT busy", 32'(bus.busy), 0);
        chk("HALT mem_req", 32'(bus.mem_req), 0);
`ifdef CPU_SEQUENCER_INSTRET_EN
        chk("HALT instret", bus.instret, ir_snap + 32'd1);
`endif
        tick();
        chk("HALT holds", 32'(bus.state_o), 5);
        bus.halt_req = 1'b0;
        tick();
        chk("HALT exit state", 32'(bus.state_o), 0);
        chk("HALT exit mem_req", 32'(bus.mem_req), 1);

        // Illegal opcode traps after DECODE; sticky until reset
        bus.opcode = 7'b1111111;
        tick();
        tick();
        chk("ILL state", 32'(bus.state_o), 6);
        chk("ILL illegal", 32'(bus.illegal), 1);
        chk("ILL busy", 32'(bus.busy), 0);
        tick();
        tick();
        chk("ILL sticky state", 32'(bus.state_o), 6);
        chk("ILL sticky illegal", 32'(bus.illegal), 1);
        chk("ILL mem_req", 32'(bus.mem_req), 0);
        reset = 1'b0;
        #1;
        chk("ILL reset illegal", 32'(bus.illegal), 0);
        chk("ILL reset state", 32'(bus.state_o), 0);

        // Reset asserted mid-handshake drops mem_req at once
        bus.mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("MID mem_req before", 32'(bus.mem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("MID mem_req async drop", 32'(bus.mem_req), 0);
        tick();

        // FETCH timeout: four wait cycles then TRAP
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("TO wait state", 32'(bus.state_o), 0);
            chk("TO wait mem_req", 32'(bus.mem_req), 1);
            tick();
        end
        chk("TO trap state", 32'(bus.state_o), 6);
        chk("TO trap mem_req", 32'(bus.mem_req), 0);
        chk("TO trap illegal", 32'(bus.illegal), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
